// File: rtl/q_divide_top.sv
// q_divide_top: signed fixed-point divider, quotient = (dividend << Q_BITS) / divisor.
// Pairs are popped from upstream FWFT FIFOs and divided by an iterative restoring
// divider, one quotient bit per cycle. Results are saturated to D_WIDTH and queued
// in an internal FWFT output FIFO.
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-low reset
//   dividend   signed Q operand, valid while in_empty=0
//   divisor    signed Q operand, valid while in_empty=0
//   in_empty   upstream has no pair available
//   in_rd_en   pop strobe to the upstream FIFOs
//   out_empty  output FIFO empty
//   out_rd_en  pop strobe from the consumer
//   out_dout   head of the output FIFO (0 while empty)
//
// Handshake: both sides use FIFO semantics. Upstream "valid" is !in_empty and our
// "ready" is the in_rd_en strobe; a pair transfers on every rising edge where
// in_rd_en=1. Downstream "valid" is !out_empty and the consumer's "ready" is
// out_rd_en; an entry transfers on every rising edge where both are high, and
// out_rd_en while empty has no effect.
module q_divide_top #(
  parameter int Q_BITS    = 10,
  parameter int D_WIDTH   = 32,
  parameter int OUT_DEPTH = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [D_WIDTH-1:0] dividend,
  input  logic [D_WIDTH-1:0] divisor,
  input  logic               in_empty,
  output logic               in_rd_en,
  output logic               out_empty,
  input  logic               out_rd_en,
  output logic [D_WIDTH-1:0] out_dout
);

  localparam int ED_WIDTH = D_WIDTH + Q_BITS + 1;
  localparam int CW       = $clog2(ED_WIDTH);
  localparam int PW       = $clog2(OUT_DEPTH);

  localparam logic [D_WIDTH-1:0]  MAX_POS = {1'b0, {(D_WIDTH-1){1'b1}}};
  localparam logic [D_WIDTH-1:0]  MAX_NEG = {1'b1, {(D_WIDTH-1){1'b0}}};
  localparam logic [ED_WIDTH-1:0] POS_LIM = ED_WIDTH'(MAX_POS);
  localparam logic [ED_WIDTH-1:0] NEG_LIM = ED_WIDTH'(MAX_NEG);

  typedef enum logic [1:0] {IDLE, DIV, FINISH} state_t;

  state_t              state;
  state_t              debug_state;  // observation point for checkers
  logic [CW-1:0]       iter;
  logic [ED_WIDTH-1:0] quo;          // shifted dividend in, quotient bits out
  logic [D_WIDTH-1:0]  rem;
  logic [D_WIDTH-1:0]  dvsr;
  logic                sign;
  logic                divzero;

  logic [D_WIDTH-1:0]  dividend_mag;
  logic [D_WIDTH-1:0]  divisor_mag;
  logic [D_WIDTH:0]    trial;
  logic                ge;
  logic [D_WIDTH-1:0]  diff;
  logic [D_WIDTH-1:0]  result;

  logic [D_WIDTH-1:0]  mem [OUT_DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [PW:0]         count;
  logic                fifo_full;
  logic                fifo_wr;
  logic                fifo_rd;

  assign debug_state = state;

  // Magnitudes: the most negative operand maps to 2^(D_WIDTH-1) as an unsigned value.
  assign dividend_mag = dividend[D_WIDTH-1] ? -dividend : dividend;
  assign divisor_mag  = divisor[D_WIDTH-1]  ? -divisor  : divisor;

  // Restoring step: shift the next dividend bit into the partial remainder. The
  // remainder stays below the divisor, so the low D_WIDTH bits of the difference
  // are exact whenever the trial is not smaller than the divisor.
  assign trial = {rem, quo[ED_WIDTH-1]};
  assign ge    = (trial >= {1'b0, dvsr});
  assign diff  = trial[D_WIDTH-1:0] - dvsr;

  // Sign and saturation applied to the magnitude quotient.
  always_comb begin
    result = quo[D_WIDTH-1:0];
    if (divzero) begin
      result = sign ? MAX_NEG : MAX_POS;
    end else if (!sign) begin
      result = (quo > POS_LIM) ? MAX_POS : quo[D_WIDTH-1:0];
    end else begin
      result = (quo > NEG_LIM) ? MAX_NEG : -quo[D_WIDTH-1:0];
    end
  end

  // Gated by reset so no pair is consumed while the block is held in reset.
  assign in_rd_en = reset && (state == IDLE) && !in_empty && !fifo_full;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      iter    <= '0;
      quo     <= '0;
      rem     <= '0;
      dvsr    <= '0;
      sign    <= 1'b0;
      divzero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_rd_en) begin
            quo     <= {{(ED_WIDTH-D_WIDTH-Q_BITS){1'b0}}, dividend_mag, {Q_BITS{1'b0}}};
            rem     <= '0;
            dvsr    <= divisor_mag;
            sign    <= dividend[D_WIDTH-1] ^ divisor[D_WIDTH-1];
            divzero <= (divisor == '0);
            iter    <= '0;
            state   <= DIV;
          end
        end
        DIV: begin
          rem <= ge ? diff : trial[D_WIDTH-1:0];
          quo <= {quo[ED_WIDTH-2:0], ge};
          if (iter == CW'(ED_WIDTH-1)) begin
            state <= FINISH;
          end else begin
            iter <= iter + CW'(1);
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Output FIFO. A write only happens in FINISH, and a pair is accepted only when
  // the FIFO is not full, so the single in-flight result always has room.
  assign fifo_wr   = (state == FINISH);
  assign fifo_rd   = out_rd_en && (count != '0);
  assign out_empty = (count == '0);
  assign fifo_full = (count == (PW+1)'(OUT_DEPTH));
  assign out_dout  = out_empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + PW'(1);
      if (fifo_rd) rd_ptr <= rd_ptr + PW'(1);
      case ({fifo_wr, fifo_rd})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (fifo_wr) mem[wr_ptr] <= result;
  end

endmodule

// File: tb/tb_q_divide_top.sv
module tb_q_divide_top;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        in_empty = 1'b1;
  logic        in_rd_en;
  logic        out_empty;
  logic        out_rd_en = 1'b0;
  logic [31:0] out_dout;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_accepted = 0;
  int accept_cyc = 0;

  logic [31:0] up_a[$];
  logic [31:0] up_b[$];
  logic [31:0] exp_q[$];

  localparam logic [31:0] QA [7] = '{32'h00000C00, 32'h00000400, 32'hFFFFFC00, 32'hFFFFE200,
                                     32'hFFFFE800, 32'h00000000, 32'hFFFFFFFF};
  localparam logic [31:0] QB [7] = '{32'h00000400, 32'h00000C00, 32'h00000C00, 32'h00000A00,
                                     32'hFFFFF800, 32'hFFFFFC00, 32'h7FFFFFFF};
  localparam logic [31:0] QE [7] = '{32'h00000C00, 32'h00000155, 32'hFFFFFEAB, 32'hFFFFF400,
                                     32'h00000C00, 32'h00000000, 32'h00000000};

  localparam logic [31:0] SA [6] = '{32'h00000400, 32'hFFFFFC00, 32'h7FFFFFFF, 32'h00000000,
                                     32'h80000000, 32'h80000000};
  localparam logic [31:0] SB [6] = '{32'h00000000, 32'h00000000, 32'h00000001, 32'h00000000,
                                     32'h00000400, 32'hFFFFFC00};
  localparam logic [31:0] SE [6] = '{32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h7FFFFFFF,
                                     32'h80000000, 32'h7FFFFFFF};

  q_divide_top dut (
    .clock     (clock),
    .reset     (reset),
    .dividend  (dividend),
    .divisor   (divisor),
    .in_empty  (in_empty),
    .in_rd_en  (in_rd_en),
    .out_empty (out_empty),
    .out_rd_en (out_rd_en),
    .out_dout  (out_dout)
  );

  // Clock and cycle counter
  initial forever #5 clock = ~clock;
  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Upstream FWFT FIFO model: in_rd_en is sampled mid-cycle, the pop lands just
  // after the edge that consumed the pair.
  initial begin : upstream
    logic take;
    forever begin
      @(negedge clock);
      take = in_rd_en;
      @(posedge clock);
      #1;
      if (take && up_a.size() > 0) begin
        void'(up_a.pop_front());
        void'(up_b.pop_front());
        n_accepted++;
        accept_cyc = cyc;
      end
      if (up_a.size() > 0) begin
        dividend = up_a[0];
        divisor  = up_b[0];
        in_empty = 1'b0;
      end else begin
        in_empty = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset;
    repeat (3) @(negedge clock);
    total++;
    if (out_empty !== 1'b1) begin
      bad++; $display("FAIL reset out_empty: got %b want 1", out_empty);
    end
    total++;
    if (out_dout !== 32'h0) begin
      bad++; $display("FAIL reset out_dout: got %h want 00000000", out_dout);
    end
    up_a.push_back(32'h00000C00);
    up_b.push_back(32'h00000400);
    repeat (3) @(negedge clock);
    total++;
    if (in_rd_en !== 1'b0 || n_accepted != 0) begin
      bad++; $display("FAIL reset in_rd_en: got %b accepted %0d want 0", in_rd_en, n_accepted);
    end
    up_a.delete();
    up_b.delete();
    repeat (2) @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    total++;
    if (out_empty !== 1'b1) begin
      bad++; $display("FAIL reset release out_empty: got %b want 1", out_empty);
    end
  endtask

  task automatic test_quotients;
    logic [31:0] expv;
    int n0;
    int t;
    for (int i = 0; i < 7; i++) begin
      n0 = n_accepted;
      up_a.push_back(QA[i]);
      up_b.push_back(QB[i]);
      exp_q.push_back(QE[i]);
      t = 0;
      while (n_accepted == n0 && t < 20) begin @(negedge clock); t++; end
      total++;
      if (n_accepted == n0) begin
        bad++; $display("FAIL quot[%0d] accept: got 0 pops want 1", i);
      end
      t = 0;
      while (out_empty && t < 100) begin @(negedge clock); t++; end
      total++;
      if (cyc - accept_cyc !== 44) begin
        bad++; $display("FAIL quot[%0d] latency: got %0d want 44", i, cyc - accept_cyc);
      end
      expv = exp_q.pop_front();
      total++;
      if (out_dout !== expv) begin
        bad++; $display("FAIL quot[%0d] value: got %h want %h", i, out_dout, expv);
      end
      out_rd_en = 1'b1;
      @(posedge clock);
      #1 out_rd_en = 1'b0;
      @(negedge clock);
      total++;
      if (out_empty !== 1'b1) begin
        bad++; $display("FAIL quot[%0d] drained: got out_empty=%b want 1", i, out_empty);
      end
    end
  endtask

  task automatic test_saturation;
    logic [31:0] expv;
    int n0;
    int t;
    for (int i = 0; i < 6; i++) begin
      n0 = n_accepted;
      up_a.push_back(SA[i]);
      up_b.push_back(SB[i]);
      exp_q.push_back(SE[i]);
      t = 0;
      while (n_accepted == n0 && t < 20) begin @(negedge clock); t++; end
      total++;
      if (n_accepted == n0) begin
        bad++; $display("FAIL sat[%0d] accept: got 0 pops want 1", i);
      end
      t = 0;
      while (out_empty && t < 100) begin @(negedge clock); t++; end
      total++;
      if (cyc - accept_cyc !== 44) begin
        bad++; $display("FAIL sat[%0d] latency: got %0d want 44", i, cyc - accept_cyc);
      end
      expv = exp_q.pop_front();
      total++;
      if (out_dout !== expv) begin
        bad++; $display("FAIL sat[%0d] value: got %h want %h", i, out_dout, expv);
      end
      out_rd_en = 1'b1;
      @(posedge clock);
      #1 out_rd_en = 1'b0;
      @(negedge clock);
      total++;
      if (out_empty !== 1'b1) begin
        bad++; $display("FAIL sat[%0d] drained: got out_empty=%b want 1", i, out_empty);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] a;
    logic [31:0] expv;
    int n0;
    int t;
    int got;
    int rd_seen;
    n0 = n_accepted;
    for (int i = 1; i <= 20; i++) begin
      a = 32'(i * 1024);
      if (i % 2 == 1) a = -a;
      up_a.push_back(a);
      up_b.push_back(32'h00000400);
      exp_q.push_back(a);
    end
    rd_seen = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clock);
      if (c >= 800 && in_rd_en) rd_seen++;
    end
    total++;
    if (n_accepted - n0 != 16) begin
      bad++; $display("FAIL bp accepted: got %0d want 16", n_accepted - n0);
    end
    total++;
    if (rd_seen != 0) begin
      bad++; $display("FAIL bp in_rd_en while full: got %0d cycles high want 0", rd_seen);
    end
    out_rd_en = 1'b1;
    got = 0;
    t = 0;
    while (got < 20 && t < 2000) begin
      if (!out_empty) begin
        expv = exp_q.pop_front();
        total++;
        if (out_dout !== expv) begin
          bad++; $display("FAIL bp result[%0d]: got %h want %h", got, out_dout, expv);
        end
        got++;
      end
      @(negedge clock);
      t++;
    end
    out_rd_en = 1'b0;
    total++;
    if (got != 20) begin
      bad++; $display("FAIL bp result count: got %0d want 20", got);
    end
    repeat (3) @(negedge clock);
    total++;
    if (out_empty !== 1'b1 || n_accepted - n0 != 20) begin
      bad++; $display("FAIL bp final: got out_empty=%b accepted=%0d want 1 and 20",
                      out_empty, n_accepted - n0);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] expv;
    int n0;
    int t;
    // Leave one finished result sitting in the output FIFO.
    up_a.push_back(32'h00000C00);
    up_b.push_back(32'h00000400);
    t = 0;
    while (out_empty && t < 120) begin @(negedge clock); t++; end
    total++;
    if (out_empty !== 1'b0) begin
      bad++; $display("FAIL mid prefill: got out_empty=%b want 0", out_empty);
    end
    // Start a second division and abort it partway through.
    n0 = n_accepted;
    up_a.push_back(32'h00000400);
    up_b.push_back(32'h00000C00);
    t = 0;
    while (n_accepted == n0 && t < 20) begin @(negedge clock); t++; end
    repeat (20) @(negedge clock);
    reset = 1'b0;
    #1;
    total++;
    if (out_empty !== 1'b1) begin
      bad++; $display("FAIL mid reset out_empty: got %b want 1", out_empty);
    end
    total++;
    if (out_dout !== 32'h0) begin
      bad++; $display("FAIL mid reset out_dout: got %h want 00000000", out_dout);
    end
    up_a.push_back(32'hFFFFE800);
    up_b.push_back(32'hFFFFF800);
    exp_q.push_back(32'h00000C00);
    n0 = n_accepted;
    repeat (3) @(negedge clock);
    total++;
    if (in_rd_en !== 1'b0 || n_accepted != n0) begin
      bad++; $display("FAIL mid reset in_rd_en: got %b want 0", in_rd_en);
    end
    @(posedge clock);
    #1 reset = 1'b1;
    t = 0;
    while (n_accepted == n0 && t < 20) begin @(negedge clock); t++; end
    total++;
    if (n_accepted == n0) begin
      bad++; $display("FAIL mid accept after release: got 0 pops want 1");
    end
    t = 0;
    while (out_empty && t < 100) begin @(negedge clock); t++; end
    total++;
    if (cyc - accept_cyc !== 44) begin
      bad++; $display("FAIL mid latency: got %0d want 44", cyc - accept_cyc);
    end
    expv = exp_q.pop_front();
    total++;
    if (out_dout !== expv) begin
      bad++; $display("FAIL mid value: got %h want %h", out_dout, expv);
    end
    out_rd_en = 1'b1;
    @(posedge clock);
    #1 out_rd_en = 1'b0;
    repeat (3) @(negedge clock);
    total++;
    if (out_empty !== 1'b1) begin
      bad++; $display("FAIL mid stray entry: got out_empty=%b out_dout=%h want empty",
                      out_empty, out_dout);
    end
  endtask

  initial begin
    test_reset();
    test_quotients();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/q_divide_top.md
Name: q_divide_top

Overview:
Signed fixed-point divider with FIFO-style input and output interfaces. It pops one dividend/divisor pair from upstream first-word-fall-through (FWFT) FIFOs and computes quotient = (dividend << Q_BITS) / divisor with an iterative restoring divider. Each result goes into an internal FWFT output FIFO. It serves the ray-tracer datapath wherever Q-format division is needed.

Parameters:
Q_BITS, 10, number of fractional bits in the Q format for all operands and results
D_WIDTH, 32, width of operands and result (two's complement)
ED_WIDTH, D_WIDTH+Q_BITS+1 (43), internal expanded width of the shifted dividend; also the iteration count (derived, not overridden)
OUT_DEPTH, 16, output FIFO depth in entries (power of 2)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
dividend  in  D_WIDTH  signed Q operand; valid while in_empty=0
divisor  in  D_WIDTH  signed Q operand; valid while in_empty=0
in_empty  in  1  upstream has no pair available
in_rd_en  out  1  pop strobe to upstream FIFOs
out_empty  out  1  output FIFO empty
out_rd_en  in  1  pop strobe from consumer
out_dout  out  D_WIDTH  head of output FIFO (FWFT)

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low.
- Reset (reset=0): state=IDLE, datapath registers cleared, output FIFO pointers and count=0, out_empty=1, out_dout=0, in_rd_en=0.
- States: IDLE, DIV, FINISH.
- IDLE: in_rd_en is combinational, = (state==IDLE) && !in_empty && !fifo_full.
  - On an edge with in_rd_en=1: latch |dividend| << Q_BITS into an ED_WIDTH remainder/quotient register and |divisor| into the divisor register.
  - Record sign = sign(dividend) XOR sign(divisor) and divzero = (divisor==0).
  - Clear the iteration counter; go to DIV.
- DIV: one restoring step per cycle, MSB first, producing one quotient bit each cycle; exactly ED_WIDTH cycles, then go to FINISH.
- FINISH:
  - Magnitude quotient truncates toward zero.
  - Apply sign by two's-complement negation.
  - Saturate:
    - Positive result > 2^(D_WIDTH-1)-1 -> 0x7FFFFFFF.
    - Negative result < -2^(D_WIDTH-1) -> 0x80000000.
    - divzero: sign=0 or dividend=0 -> 0x7FFFFFFF; sign=1 -> 0x80000000.
  - Write the result to the output FIFO; go to IDLE.
- Latency: out_empty falls after edge ED_WIDTH+1 counted from the edge that samples in_rd_en, i.e. 44 cycles with defaults.
  - Throughput: one result per ED_WIDTH+2 cycles.
  - in_rd_en may reassert on the cycle after FINISH.
- Output FIFO:
  - FWFT: out_dout shows the oldest entry whenever out_empty=0.
  - out_rd_en pops on the rising edge; out_rd_en while empty is ignored.
  - A simultaneous write and pop when full or empty is legal; count is updated correctly and order is preserved.
  - Pointers wrap modulo OUT_DEPTH.
- Backpressure: no pair is accepted while the FIFO is full. In-flight operations always have room, because acceptance requires !fifo_full and only one operation is in flight.
- Results are strictly in input order.
- Reset asserted mid-operation aborts the division with no partial write and empties the FIFO.

Test Plan:
- 3.0/1.0: dividend 0x00000C00, divisor 0x00000400 -> out_dout 0x00000C00, out_empty falls 44 cycles after in_rd_en.
- 1.0/3.0: 0x00000400 / 0x00000C00 -> 0x00000155 (truncated 341). -1.0/3.0: 0xFFFFFC00 / 0x00000C00 -> 0xFFFFFEAB (-341).
- -7.5/2.5: 0xFFFFE200 / 0x00000A00 -> 0xFFFFF400. -6.0/-2.0: 0xFFFFE800 / 0xFFFFF800 -> 0x00000C00.
- Saturation:
  - 0x00000400 / 0 -> 0x7FFFFFFF.
  - 0xFFFFFC00 / 0 -> 0x80000000.
  - 0x7FFFFFFF / 0x00000001 -> 0x7FFFFFFF.
- Backpressure: stream 20 pairs with out_rd_en=0 -> exactly 16 accepted and in_rd_en stays 0; then pop continuously -> 20 results in order, no loss or duplication.
- Reset mid-operation: reset=0 at cycle 20 of DIV -> out_empty=1 immediately. After release, the next pair yields the correct result with normal latency.
